// File: rtl/line_xfer_ctrl.sv
// line_xfer_ctrl
//   Sequences one cache-line transfer between the cache SRAM and SDRAM:
//   an optional write-back of the evicted line (WB) followed by an optional
//   fill of the requested line (FILL), one word per slot of SDRAM_LAT+1
//   cycles, finishing with a single-cycle DONE.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle request pulse (sampled in IDLE only)
//   wb_req, fill_req           requested phases
//   index, old_tag, new_tag    line index and tags, captured on start
//   busy, done                 transfer status / completion pulse
//   Address_sdram, wr_rd_sdram, mstrb_sdram   SDRAM word access
//   address_sram, wen_sram     cache SRAM word access
//   mux_sel, demux_sel         data-path steering (SRAM->SDRAM, SDRAM->SRAM)
module line_xfer_ctrl #(
  parameter int ADDR_WIDTH      = 16,
  parameter int ADDR_WIDTH_SRAM = 8,
  parameter int TAG_SIZE        = 8,
  parameter int INDEX_SIZE      = 3,
  parameter int OFFSET_SIZE     = 5,
  parameter int SDRAM_LAT       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       wb_req,
  input  logic                       fill_req,
  input  logic [INDEX_SIZE-1:0]      index,
  input  logic [TAG_SIZE-1:0]        old_tag,
  input  logic [TAG_SIZE-1:0]        new_tag,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      Address_sdram,
  output logic                       wr_rd_sdram,
  output logic                       mstrb_sdram,
  output logic [ADDR_WIDTH_SRAM-1:0] address_sram,
  output logic                       wen_sram,
  output logic                       mux_sel,
  output logic                       demux_sel
);

  localparam int SLOT_W = (SDRAM_LAT > 0) ? $clog2(SDRAM_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 nxt_state_s;
  logic [SLOT_W-1:0]      slot_r;
  logic [SLOT_W-1:0]      nxt_slot_s;
  logic [OFFSET_SIZE-1:0] offset_r;
  logic [OFFSET_SIZE-1:0] nxt_offset_s;
  logic                   cap_fill_r;
  logic [INDEX_SIZE-1:0]  cap_index_r;
  logic [TAG_SIZE-1:0]    cap_old_tag_r;
  logic [TAG_SIZE-1:0]    cap_new_tag_r;
  logic                   slot_last_s;
  logic                   offset_last_s;
  logic [INDEX_SIZE-1:0]  eff_index_s;
  logic [TAG_SIZE-1:0]    eff_old_tag_s;
  logic [TAG_SIZE-1:0]    eff_new_tag_s;

  assign slot_last_s   = (slot_r == SLOT_W'(SDRAM_LAT));
  assign offset_last_s = &offset_r;

  // Line fields for the next cycle: the live inputs on the start edge (the
  // capture registers are only loaded at that same edge), captured copies after.
  always_comb begin
    if (state_r == IDLE) begin
      eff_index_s   = index;
      eff_old_tag_s = old_tag;
      eff_new_tag_s = new_tag;
    end else begin
      eff_index_s   = cap_index_r;
      eff_old_tag_s = cap_old_tag_r;
      eff_new_tag_s = cap_new_tag_r;
    end
  end

  // Next-state, slot and offset computation; outputs are registered from these.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_slot_s   = slot_r;
    nxt_offset_s = offset_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nxt_slot_s   = '0;
          nxt_offset_s = '0;
          if (wb_req) begin
            nxt_state_s = WB;
          end else if (fill_req) begin
            nxt_state_s = FILL;
          end else begin
            nxt_state_s = DONE;
          end
        end else begin
          nxt_state_s = IDLE;
        end
      end
      WB, FILL: begin
        if (slot_last_s) begin
          nxt_slot_s   = '0;
          nxt_offset_s = offset_r + OFFSET_SIZE'(1);
          if (offset_last_s) begin
            // Offset wraps to 0, which is also the start offset of a following FILL.
            if ((state_r == WB) && cap_fill_r) begin
              nxt_state_s = FILL;
            end else begin
              nxt_state_s = DONE;
            end
          end else begin
            nxt_state_s = state_r;
          end
        end else begin
          nxt_slot_s = slot_r + SLOT_W'(1);
        end
      end
      DONE: begin
        nxt_state_s = IDLE;
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // State, counters, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      slot_r        <= '0;
      offset_r      <= '0;
      cap_fill_r    <= 1'b0;
      cap_index_r   <= '0;
      cap_old_tag_r <= '0;
      cap_new_tag_r <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      Address_sdram <= '0;
      wr_rd_sdram   <= 1'b0;
      mstrb_sdram   <= 1'b0;
      address_sram  <= '0;
      wen_sram      <= 1'b0;
      mux_sel       <= 1'b0;
      demux_sel     <= 1'b0;
    end else begin
      state_r  <= nxt_state_s;
      slot_r   <= nxt_slot_s;
      offset_r <= nxt_offset_s;
      if ((state_r == IDLE) && start) begin
        cap_fill_r    <= fill_req;
        cap_index_r   <= index;
        cap_old_tag_r <= old_tag;
        cap_new_tag_r <= new_tag;
      end else begin
        cap_fill_r    <= cap_fill_r;
        cap_index_r   <= cap_index_r;
        cap_old_tag_r <= cap_old_tag_r;
        cap_new_tag_r <= cap_new_tag_r;
      end
      busy        <= (nxt_state_s != IDLE);
      done        <= (nxt_state_s == DONE);
      mstrb_sdram <= ((nxt_state_s == WB) || (nxt_state_s == FILL)) && (nxt_slot_s == '0);
      wr_rd_sdram <= (nxt_state_s == WB);
      mux_sel     <= (nxt_state_s == WB);
      demux_sel   <= (nxt_state_s == FILL);
      // SRAM write lands in the last slot cycle, once the SDRAM read data is valid.
      wen_sram    <= (nxt_state_s == FILL) && (nxt_slot_s == SLOT_W'(SDRAM_LAT));
      if (nxt_state_s == WB) begin
        Address_sdram <= ADDR_WIDTH'({eff_old_tag_s, eff_index_s, nxt_offset_s});
        address_sram  <= ADDR_WIDTH_SRAM'({eff_index_s, nxt_offset_s});
      end else if (nxt_state_s == FILL) begin
        Address_sdram <= ADDR_WIDTH'({eff_new_tag_s, eff_index_s, nxt_offset_s});
        address_sram  <= ADDR_WIDTH_SRAM'({eff_index_s, nxt_offset_s});
      end else begin
        Address_sdram <= Address_sdram;
        address_sram  <= address_sram;
      end
    end
  end

endmodule
